// File: rtl/ddr4_rdimm_cmd_driver.sv
// DDR4 RDIMM register input-bus command driver: valid/ready command intake, MRS side-A/side-B split, rank-1 address mirroring.
// Define DDR4_RDIMM_CMD_PARITY_EN to drive even command/address parity on DPAR; otherwise DPAR is tied low.

module ddr4_rdimm_cmd_driver #(
  parameter int unsigned MRS_GAP      = 8,
  parameter string       MC_CA_MIRROR = "OFF"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_type,
  input  logic        cmd_rank,
  input  logic [1:0]  cmd_bg,
  input  logic [1:0]  cmd_ba,
  input  logic [17:0] cmd_addr,
  input  logic [1:0]  cke_in,
  input  logic [1:0]  odt_in,
  output logic [17:0] DA,
  output logic [1:0]  DBA,
  output logic [1:0]  DBG,
  output logic        DACT_n,
  output logic        DCS0_n,
  output logic        DCS1_n,
  output logic        DPAR,
  output logic [1:0]  DCKE,
  output logic [1:0]  DODT,
  output logic        cmd_err
);

  localparam logic [2:0]  CMD_DES  = 3'd0;
  localparam logic [2:0]  CMD_ACT  = 3'd1;
  localparam logic [2:0]  CMD_RD   = 3'd2;
  localparam logic [2:0]  CMD_WR   = 3'd3;
  localparam logic [2:0]  CMD_PRE  = 3'd4;
  localparam logic [2:0]  CMD_REF  = 3'd5;
  localparam logic [2:0]  CMD_MRS  = 3'd6;
  localparam logic [2:0]  CMD_RSVD = 3'd7;

  localparam logic [17:0] DES_DA      = 18'h1C000;
  localparam logic [17:0] SIDE_B_MASK = 18'h22BF8;
  localparam bit          MIRROR_ON   = (MC_CA_MIRROR == "ON");
  localparam logic [7:0]  GAP_LOAD    = 8'(MRS_GAP - 1);

  typedef struct packed {
    logic        cs0n;
    logic        cs1n;
    logic        actn;
    logic [17:0] da;
    logic [1:0]  ba;
    logic [1:0]  bg;
  } pins_t;

  typedef enum logic [1:0] {
    IDLE,
    MRS_A,
    GAP,
    MRS_B
  } state_t;

  function automatic pins_t desPins();
    pins_t p;
    p.cs0n = 1'b1;
    p.cs1n = 1'b1;
    p.actn = 1'b1;
    p.da   = DES_DA;
    p.ba   = 2'b00;
    p.bg   = 2'b00;
    return p;
  endfunction

  // Odd-rank mirroring swaps the pin pairs the DIMM routes crosswise on the back side.
  function automatic pins_t applyMirror(input pins_t p, input logic rank);
    pins_t m;
    m = p;
    if (MIRROR_ON && rank) begin
      m.da[3]  = p.da[4];
      m.da[4]  = p.da[3];
      m.da[5]  = p.da[6];
      m.da[6]  = p.da[5];
      m.da[7]  = p.da[8];
      m.da[8]  = p.da[7];
      m.da[11] = p.da[13];
      m.da[13] = p.da[11];
      m.ba     = {p.ba[0], p.ba[1]};
      m.bg     = {p.bg[0], p.bg[1]};
    end
    return m;
  endfunction

  function automatic logic [2:0] opCode(input logic [2:0] t);
    logic [2:0] c;
    case (t)
      CMD_RD:  c = 3'b101;
      CMD_WR:  c = 3'b100;
      CMD_PRE: c = 3'b010;
      CMD_REF: c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  state_t      state_q;
  logic        ready_q;
  logic [7:0]  gapCnt_q;
  logic        err_q;
  pins_t       pins_q;
  logic [1:0]  cke_q;
  logic [1:0]  odt_q;
  logic [17:0] mrsDa_q;
  logic [1:0]  mrsBa_q;
  logic        mrsBg0_q;
  logic        mrsRank_q;

  pins_t       encPins_d;
  logic        encErr_d;
  pins_t       sideB_d;
  pins_t       pins_d;
  logic [17:0] mrsDa_d;
  logic        accept_d;

  assign accept_d = cmd_valid && ready_q;
  assign mrsDa_d  = {cmd_addr[17], 3'b000, cmd_addr[13:0]};

  always_comb begin
    encPins_d = desPins();
    encErr_d  = 1'b0;
    case (cmd_type)
      CMD_ACT: begin
        encPins_d.cs0n = cmd_rank;
        encPins_d.cs1n = ~cmd_rank;
        encPins_d.actn = 1'b0;
        encPins_d.da   = cmd_addr;
        encPins_d.ba   = cmd_ba;
        encPins_d.bg   = cmd_bg;
      end
      CMD_RD, CMD_WR, CMD_PRE, CMD_REF: begin
        encPins_d.cs0n = cmd_rank;
        encPins_d.cs1n = ~cmd_rank;
        encPins_d.da   = {cmd_addr[17], opCode(cmd_type), cmd_addr[13:0]};
        encPins_d.ba   = cmd_ba;
        encPins_d.bg   = cmd_bg;
      end
      CMD_MRS: begin
        encPins_d.cs0n = cmd_rank;
        encPins_d.cs1n = ~cmd_rank;
        encPins_d.da   = mrsDa_d;
        encPins_d.ba   = cmd_ba;
        encPins_d.bg   = {1'b0, cmd_bg[0]};
      end
      CMD_RSVD: encErr_d = 1'b1;
      default: ;
    endcase
    encPins_d = applyMirror(encPins_d, cmd_rank);
  end

  // Side-B copy is pre-inverted so the register's B-side inversion restores the original value.
  always_comb begin
    sideB_d      = desPins();
    sideB_d.cs0n = mrsRank_q;
    sideB_d.cs1n = ~mrsRank_q;
    sideB_d.da   = mrsDa_q ^ SIDE_B_MASK;
    sideB_d.ba   = ~mrsBa_q;
    sideB_d.bg   = {1'b1, ~mrsBg0_q};
    sideB_d      = applyMirror(sideB_d, mrsRank_q);
  end

  always_comb begin
    pins_d = desPins();
    case (state_q)
      IDLE:    if (accept_d) pins_d = encPins_d;
      MRS_A:   if (MRS_GAP == 0) pins_d = sideB_d;
      GAP:     if (gapCnt_q == 8'd0) pins_d = sideB_d;
      default: ;
    endcase
  end

`ifdef DDR4_RDIMM_CMD_PARITY_EN
  logic dpar_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      gapCnt_q  <= 8'd0;
      err_q     <= 1'b0;
      pins_q    <= desPins();
      cke_q     <= 2'b00;
      odt_q     <= 2'b00;
      mrsDa_q   <= 18'd0;
      mrsBa_q   <= 2'b00;
      mrsBg0_q  <= 1'b0;
      mrsRank_q <= 1'b0;
`ifdef DDR4_RDIMM_CMD_PARITY_EN
      dpar_q    <= 1'b0;
`endif
    end else begin
      cke_q  <= cke_in;
      odt_q  <= odt_in;
      pins_q <= pins_d;
      err_q  <= 1'b0;
`ifdef DDR4_RDIMM_CMD_PARITY_EN
      dpar_q <= ^{pins_d.actn, pins_d.da, pins_d.ba, pins_d.bg};
`endif
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            err_q <= encErr_d;
            if (cmd_type == CMD_MRS) begin
              state_q   <= MRS_A;
              ready_q   <= 1'b0;
              mrsDa_q   <= mrsDa_d;
              mrsBa_q   <= cmd_ba;
              mrsBg0_q  <= cmd_bg[0];
              mrsRank_q <= cmd_rank;
            end
          end
        end
        MRS_A: begin
          if (MRS_GAP == 0) begin
            state_q <= MRS_B;
          end else begin
            state_q  <= GAP;
            gapCnt_q <= GAP_LOAD;
          end
        end
        GAP: begin
          if (gapCnt_q == 8'd0) begin
            state_q <= MRS_B;
          end else begin
            gapCnt_q <= gapCnt_q - 8'd1;
          end
        end
        MRS_B: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign cmd_err   = err_q;
  assign DA        = pins_q.da;
  assign DBA       = pins_q.ba;
  assign DBG       = pins_q.bg;
  assign DACT_n    = pins_q.actn;
  assign DCS0_n    = pins_q.cs0n;
  assign DCS1_n    = pins_q.cs1n;
  assign DCKE      = cke_q;
  assign DODT      = odt_q;
`ifdef DDR4_RDIMM_CMD_PARITY_EN
  assign DPAR      = dpar_q;
`else
  assign DPAR      = 1'b0;
`endif

endmodule

// File: tb/tb_ddr4_rdimm_cmd_driver.sv
// Directed bench for ddr4_rdimm_cmd_driver: a default instance (MRS_GAP=8, no mirroring) and a mirrored instance with MRS_GAP=0.
// Expected pin snapshots are queued as each cycle's stimulus is driven and compared after the following clock edge.

module tb_ddr4_rdimm_cmd_driver;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] ckeIn, odtIn;

  logic        valid0, valid1;
  logic [2:0]  type0, type1;
  logic        rank0, rank1;
  logic [1:0]  bg0, bg1, ba0, ba1;
  logic [17:0] addr0, addr1;

  logic        ready0, err0, act0, cs00, cs10, par0;
  logic [17:0] da0;
  logic [1:0]  dba0, dbg0, dcke0, dodt0;
  logic        ready1, err1, act1, cs01, cs11, par1;
  logic [17:0] da1;
  logic [1:0]  dba1, dbg1, dcke1, dodt1;

  int compared   = 0;
  int mismatched = 0;

  string       tagQ[$];
  bit          instQ[$];
  logic [31:0] expQ[$];

  localparam logic [1:0] K = 2'b01;
  localparam logic [1:0] O = 2'b10;

  always #5 clk = ~clk;

  ddr4_rdimm_cmd_driver #(.MRS_GAP(8), .MC_CA_MIRROR("OFF")) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(valid0), .cmd_ready(ready0),
    .cmd_type(type0), .cmd_rank(rank0), .cmd_bg(bg0), .cmd_ba(ba0), .cmd_addr(addr0),
    .cke_in(ckeIn), .odt_in(odtIn), .DA(da0), .DBA(dba0), .DBG(dbg0), .DACT_n(act0),
    .DCS0_n(cs00), .DCS1_n(cs10), .DPAR(par0), .DCKE(dcke0), .DODT(dodt0), .cmd_err(err0)
  );

  ddr4_rdimm_cmd_driver #(.MRS_GAP(0), .MC_CA_MIRROR("ON")) dutM (
    .clk(clk), .rst_n(rst_n), .cmd_valid(valid1), .cmd_ready(ready1),
    .cmd_type(type1), .cmd_rank(rank1), .cmd_bg(bg1), .cmd_ba(ba1), .cmd_addr(addr1),
    .cke_in(ckeIn), .odt_in(odtIn), .DA(da1), .DBA(dba1), .DBG(dbg1), .DACT_n(act1),
    .DCS0_n(cs01), .DCS1_n(cs11), .DPAR(par1), .DCKE(dcke1), .DODT(dodt1), .cmd_err(err1)
  );

  function automatic logic [31:0] expv(input logic rdy, input logic err, input logic cs0,
                                       input logic cs1, input logic act, input logic [17:0] da,
                                       input logic [1:0] ba, input logic [1:0] bg,
                                       input logic [1:0] cke, input logic [1:0] odt);
    logic par;
`ifdef DDR4_RDIMM_CMD_PARITY_EN
    par = ^{act, da, ba, bg};
`else
    par = 1'b0;
`endif
    return {rdy, err, cs0, cs1, act, da, ba, bg, par, cke, odt};
  endfunction

  function automatic logic [31:0] desv(input logic rdy, input logic err,
                                       input logic [1:0] cke, input logic [1:0] odt);
    return expv(rdy, err, 1'b1, 1'b1, 1'b1, 18'h1C000, 2'b00, 2'b00, cke, odt);
  endfunction

  task automatic checkOutput();
    string       tag;
    bit          inst;
    logic [31:0] exp;
    logic [31:0] obs;
    compared++;
    if (expQ.size() == 0) begin
      mismatched++;
      $error("[TB] FAIL scoreboard_underflow: observed empty queue, expected an entry");
      return;
    end
    tag  = tagQ.pop_front();
    inst = instQ.pop_front();
    exp  = expQ.pop_front();
    obs  = inst ? {ready1, err1, cs01, cs11, act1, da1, dba1, dbg1, par1, dcke1, dodt1}
                : {ready0, err0, cs00, cs10, act0, da0, dba0, dbg0, par0, dcke0, dodt0};
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h (rdy,err,cs0,cs1,act,da,ba,bg,par,cke,odt)",
             tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input bit inst, input logic v, input logic [2:0] t,
                               input logic r, input logic [1:0] bg, input logic [1:0] ba,
                               input logic [17:0] a, input logic [31:0] exp);
    if (inst) begin
      valid1 = v; type1 = t; rank1 = r; bg1 = bg; ba1 = ba; addr1 = a;
      valid0 = 1'b0;
    end else begin
      valid0 = v; type0 = t; rank0 = r; bg0 = bg; ba0 = ba; addr0 = a;
      valid1 = 1'b0;
    end
    tagQ.push_back(tag);
    instQ.push_back(inst);
    expQ.push_back(exp);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idleStep(input string tag, input bit inst, input logic [31:0] exp);
    applyStimulus(tag, inst, 1'b0, 3'd0, 1'b0, 2'b00, 2'b00, 18'h0, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    ckeIn = 2'b11;
    odtIn = 2'b11;
    valid0 = 1'b0; type0 = '0; rank0 = 1'b0; bg0 = '0; ba0 = '0; addr0 = '0;
    valid1 = 1'b0; type1 = '0; rank1 = 1'b0; bg1 = '0; ba1 = '0; addr1 = '0;

    idleStep("reset_dut", 0, desv(1'b1, 1'b0, 2'b00, 2'b00));
    idleStep("reset_dutM", 1, desv(1'b1, 1'b0, 2'b00, 2'b00));

    rst_n = 1'b1;
    ckeIn = K;
    odtIn = O;
    idleStep("idle_des", 0, desv(1'b1, 1'b0, K, O));
    ckeIn = 2'b10;
    odtIn = 2'b01;
    idleStep("cke_odt_passthru", 0, desv(1'b1, 1'b0, 2'b10, 2'b01));
    ckeIn = K;
    odtIn = O;

    applyStimulus("rd_rank0", 0, 1'b1, 3'd2, 1'b0, 2'd2, 2'd1, 18'h00080,
                  expv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 18'h14080, 2'd1, 2'd2, K, O));
    idleStep("rd_then_des", 0, desv(1'b1, 1'b0, K, O));

    applyStimulus("wr_rank1", 0, 1'b1, 3'd3, 1'b1, 2'd1, 2'd3, 18'h3FFFF,
                  expv(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 18'h33FFF, 2'd3, 2'd1, K, O));
    applyStimulus("pre_b2b", 0, 1'b1, 3'd4, 1'b0, 2'd0, 2'd0, 18'h00400,
                  expv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 18'h08400, 2'd0, 2'd0, K, O));
    applyStimulus("ref_b2b", 0, 1'b1, 3'd5, 1'b1, 2'd2, 2'd1, 18'h00000,
                  expv(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 18'h04000, 2'd1, 2'd2, K, O));
    applyStimulus("act_b2b", 0, 1'b1, 3'd1, 1'b0, 2'd3, 2'd2, 18'h2A5A5,
                  expv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 18'h2A5A5, 2'd2, 2'd3, K, O));
    applyStimulus("des_type", 0, 1'b1, 3'd0, 1'b1, 2'd3, 2'd3, 18'h3FFFF, desv(1'b1, 1'b0, K, O));

    applyStimulus("mrs_side_a", 0, 1'b1, 3'd6, 1'b0, 2'b01, 2'b10, 18'h00A5A,
                  expv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 18'h00A5A, 2'b10, 2'b01, K, O));
    for (int i = 0; i < 8; i++)
      applyStimulus("mrs_gap_des", 0, 1'b1, 3'd2, 1'b0, 2'd0, 2'd0, 18'h0, desv(1'b0, 1'b0, K, O));
    applyStimulus("mrs_side_b", 0, 1'b1, 3'd2, 1'b0, 2'd0, 2'd0, 18'h0,
                  expv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 18'h221A2, 2'b01, 2'b10, K, O));
    applyStimulus("mrs_ready_back", 0, 1'b1, 3'd2, 1'b0, 2'd0, 2'd0, 18'h0, desv(1'b1, 1'b0, K, O));
    applyStimulus("rd_after_mrs", 0, 1'b1, 3'd2, 1'b0, 2'd0, 2'd0, 18'h0,
                  expv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 18'h14000, 2'd0, 2'd0, K, O));

    applyStimulus("reserved_err", 0, 1'b1, 3'd7, 1'b1, 2'd1, 2'd1, 18'h12345, desv(1'b1, 1'b1, K, O));
    idleStep("reserved_err_clear", 0, desv(1'b1, 1'b0, K, O));

    applyStimulus("mrs2_side_a", 0, 1'b1, 3'd6, 1'b1, 2'd0, 2'd0, 18'h12345,
                  expv(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 18'h02345, 2'd0, 2'd0, K, O));
    idleStep("mrs2_gap0", 0, desv(1'b0, 1'b0, K, O));
    idleStep("mrs2_gap1", 0, desv(1'b0, 1'b0, K, O));
    rst_n = 1'b0;
    idleStep("reset_in_gap", 0, desv(1'b1, 1'b0, 2'b00, 2'b00));
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++)
      idleStep("no_side_b_after_reset", 0, desv(1'b1, 1'b0, K, O));

    applyStimulus("mirror_act_r1", 1, 1'b1, 3'd1, 1'b1, 2'b01, 2'b01, 18'h00008,
                  expv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 18'h00010, 2'b10, 2'b10, K, O));
    applyStimulus("mirror_act_r0", 1, 1'b1, 3'd1, 1'b0, 2'b01, 2'b01, 18'h00008,
                  expv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 18'h00008, 2'b01, 2'b01, K, O));
    applyStimulus("mirror_rd_r1", 1, 1'b1, 3'd2, 1'b1, 2'b10, 2'b01, 18'h00800,
                  expv(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 18'h16000, 2'b10, 2'b01, K, O));
    applyStimulus("mirror_mrs_a", 1, 1'b1, 3'd6, 1'b1, 2'b01, 2'b10, 18'h00A5A,
                  expv(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 18'h0223A, 2'b01, 2'b10, K, O));
    idleStep("mirror_mrs_b_nogap", 1,
             expv(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 18'h209C2, 2'b10, 2'b01, K, O));
    idleStep("mirror_mrs_done", 1, desv(1'b1, 1'b0, K, O));

    applyStimulus("parity_act", 0, 1'b1, 3'd1, 1'b0, 2'd0, 2'd0, 18'h00001,
                  expv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 18'h00001, 2'd0, 2'd0, K, O));
    idleStep("parity_des", 0, desv(1'b1, 1'b0, K, O));

    compared++;
    assert (expQ.size() == 0) else begin
      mismatched++;
      $error("[TB] FAIL scoreboard_drain: observed %0d leftover, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ddr4_rdimm_cmd_driver.md
Name: ddr4_rdimm_cmd_driver

Overview:
- Host-side command transmitter for the DDR4 RDIMM register's input bus. Drives DA/DBA/DBG/DACT_n/DCS*_n/DPAR/DCKE/DODT.
- Takes single commands through a valid/ready handshake and encodes them onto the DDR4 command pins.
- Splits every MRS into a side-A copy and a side-B copy. The side-B copy is pre-inverted so the register's B-side inversion restores the intended value.
- Applies odd-rank address mirroring when enabled.

Parameters:
- MRS_GAP, 8: number of DES cycles between the side-A and side-B MRS copies (range 0..255).
- MC_CA_MIRROR, "OFF": "ON" applies address mirroring to all rank-1 commands.

Ports:
- clk  in  1  command clock; one DA slot per cycle.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_type  in  3  0=DES, 1=ACT, 2=RD, 3=WR, 4=PRE, 5=REF, 6=MRS, 7=reserved.
- cmd_rank  in  1  target rank (0→DCS0_n, 1→DCS1_n).
- cmd_bg  in  2  bank group (MRS: BG0 is the MR number bit 2).
- cmd_ba  in  2  bank address / MR number bits 1:0.
- cmd_addr  in  18  row/column/MR opcode.
- cke_in  in  2  CKE request, registered straight through.
- odt_in  in  2  ODT request, registered straight through.
- DA  out  18  address/command.
- DBA  out  2  bank address.
- DBG  out  2  bank group.
- DACT_n  out  1  activate.
- DCS0_n  out  1  chip select, rank 0.
- DCS1_n  out  1  chip select, rank 1.
- DPAR  out  1  command/address parity.
- DCKE  out  2  clock enable.
- DODT  out  2  on-die termination.
- cmd_err  out  1  one-cycle pulse when a reserved cmd_type is accepted.

Behaviour:
- Reset (rst_n=0 at a clk edge), DES state:
  - DCS0_n=DCS1_n=1, DACT_n=1, DA=18'h1C000 (A16:14=111), DBA=0, DBG=0, DPAR=0, DCKE=0, DODT=0, cmd_err=0.
  - FSM returns to IDLE. A reset during an MRS split aborts it; no side-B copy is issued.
- Handshake:
  - cmd_ready=1 only in IDLE and does not depend on cmd_valid.
  - A command is accepted when cmd_valid && cmd_ready at edge N; its encoding is on the pins from edge N+1 for exactly one cycle.
  - With no accepted command, pins return to DES. Back-to-back single-cycle commands are sustained at one per cycle.
- DCKE/DODT are registered from cke_in/odt_in every cycle, 1-cycle latency, independent of the FSM.
- Encoding; CS of cmd_rank low, other CS high:
  - ACT: DACT_n=0; DA=cmd_addr verbatim.
  - Other commands: DACT_n=1; DA[16:14] = RD 101, WR 100, PRE 010, REF 001, MRS 000; remaining DA bits from cmd_addr.
  - Reserved type: DES on the pins plus a cmd_err pulse at N+1.
  - DES type: DES on the pins.
- FSM states:
  - IDLE: accepted MRS → MRS_A.
  - MRS_A: 1 cycle. Side-A copy on the pins with DBG={1'b0, cmd_bg[0]} and DA/DBA as given → GAP if MRS_GAP>0, else MRS_B.
  - GAP: DES for MRS_GAP cycles via an 8-bit down-counter → MRS_B.
  - MRS_B: 1 cycle → IDLE. Side-B copy on the pins:
    - DBG={1'b1, ~cmd_bg[0]}.
    - DBA=~cmd_ba.
    - DA = cmd_addr XOR 18'h22BF8 (invert A17, A13, A11, A9:A3; A16:14, A12, A10, A2:0 untouched).
  - MRS latches all command fields at acceptance. cmd_ready stays 0 from acceptance through the MRS_B cycle.
- Mirroring, when MC_CA_MIRROR=="ON" and rank=1:
  - Swap A3/A4, A5/A6, A7/A8, A11/A13, BA0/BA1, BG0/BG1.
  - Applied after the side-B inversion, on all command types. A rank-1 MRS side select therefore appears on DBG[0].
- All command outputs come from flops; no combinational path from inputs to D* pins.

Optional Feature:
- Macro DDR4_RDIMM_CMD_PARITY_EN.
- Defined: DPAR is registered alongside the pins and equals the XOR of the driven DACT_n, DA[17:0], DBA[1:0], DBG[1:0] (even parity including DPAR) in every cycle, DES included.
- Undefined: DPAR is held at 0 and no parity logic is present.

Test Plan:
- Reset, then rst_n=1 with no commands → DES pins, DA=18'h1C000, CS both 1, cmd_ready=1.
- RD, rank0, bg=2, ba=1, addr=18'h00080, accepted at edge N → at N+1: DCS0_n=0, DACT_n=1, DA=18'h14080, DBG=2, DBA=1; DES at N+2.
- MRS, rank0, bg=2'b01, ba=2'b10, addr=18'h00A5A, MRS_GAP=8:
  - N+1: side-A copy, DA=18'h00A5A, DBG=01, DBA=10.
  - N+2..N+9: DES.
  - N+10: side-B copy, DA=18'h221A2, DBG=10, DBA=01.
  - cmd_ready returns at N+11.
- MC_CA_MIRROR="ON", ACT rank1, bg=2'b01, ba=2'b01, addr=18'h00008 → DCS1_n=0, DA=18'h00010, DBG=10, DBA=10.
- rst_n=0 asserted during GAP → next cycle DES, cmd_ready=1, no side-B copy ever appears; cmd_type=7 accepted → DES plus cmd_err=1 for exactly one cycle.
- Parity build, ACT rank0, addr=18'h00001, bg=0, ba=0 → DPAR=1; DES cycle → DPAR=0.
